// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver (16x oversampled, mid-bit sampling) feeding a show-ahead receive FIFO.
// Latency: a byte appears at the head on the clock after its stop-bit decision; a pop exposes the next head one clock later.
// Backpressure: none on the line; a good byte arriving to a full FIFO with no pop is dropped and flagged by uart_rx_overflow.
module uart_rx_fifo #(
    parameter int MAIN_CLK   = 50_000_000,
    parameter int UART_CLK   = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] uart_rx_data,
    input  logic       uart_rx_get,
    output logic       uart_rx_empty,
    output logic       uart_rx_full,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_overflow
);

    localparam int DIV = MAIN_CLK / (UART_CLK * OVERSAMPLE);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            sync1_q, rx_s_q, rx_d_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            empty_q, empty_d, full_q, full_d;
    logic            ferr_q, ferr_d, ovf_q, ovf_d;
    logic            push;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic tick, start_edge, pop;
    assign tick       = (presc_q == PW'(DIV - 1));
    assign start_edge = rx_d_q & ~rx_s_q;
    assign pop        = uart_rx_get & ~empty_q;

    // Metastability synchroniser plus one delay stage for falling-edge detection; idles high.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // Frame state machine: prescaler, oversample/bit counters and the stop-bit verdict.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        push    = 1'b0;
        ferr_d  = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // The falling edge sets the sampling phase for the whole frame.
                if (start_edge) begin
                    state_d = START;
                    presc_d = '0;
                    scnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE / 2 - 1)) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            scnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = DATA;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE - 1)) begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        scnt_d  = '0;
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                // Decide one tick early so back-to-back frames leave margin before the next start edge.
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE - 2)) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            if (!full_q || pop) begin
                                push = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == (AW + 1)'(FIFO_DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            scnt_q   <= '0;
            bcnt_q   <= '0;
            shreg_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            scnt_q   <= scnt_d;
            bcnt_q   <= bcnt_d;
            shreg_q  <= shreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    assign uart_rx_data      = empty_q ? 8'h00 : mem_q[rd_ptr_q];
    assign uart_rx_empty     = empty_q;
    assign uart_rx_full      = full_q;
    assign uart_rx_busy      = (state_q != IDLE);
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: self-checking bench for uart_rx_fifo using a queue model of received bytes.
// Latency: frames at 48 clk/bit (DIV=3, 16x); stop decision expected ~9.5 bit times after start.
// Backpressure: host pops are driven by the bench; overflow and pop-at-decision cases included.
module tb_uart_rx_fifo;

    localparam int BIT   = 48;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       get = 1'b0;
    logic [7:0] data;
    logic       empty, full, busy, ferr, ovf;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .MAIN_CLK(5_000_000), .UART_CLK(100_000), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_50M(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .uart_rx_data(data), .uart_rx_get(get), .uart_rx_empty(empty),
        .uart_rx_full(full), .uart_rx_busy(busy),
        .uart_rx_frame_err(ferr), .uart_rx_overflow(ovf)
    );

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int exp_ferr = 0;
    int exp_ovf = 0;
    int lat = 0;
    bit model_valid = 1'b0;
    logic [7:0] mq [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the byte-queue model, plus pulse counting.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (ferr) ferr_cnt++;
            if (ovf)  ovf_cnt++;
        end
        if (rst_n && model_valid) begin
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("data", int'(data), (mq.size() != 0) ? int'(mq[0]) : 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        chk("busy_in_frame", int'(busy), 1);
        uart_rx = stop;
        model_valid = 1'b0;
        repeat (38) @(negedge clk);
        chk("busy_after_stop", int'(busy), 0);
        repeat (BIT - 38) @(negedge clk);
        if (stop) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else exp_ovf++;
        end else begin
            exp_ferr++;
        end
        model_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_expect(input logic [7:0] e);
        @(negedge clk);
        chk("pop_head", int'(data), int'(e));
        get = 1'b1;
        if (mq.size() != 0) void'(mq.pop_front());
        @(negedge clk);
        get = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_data", int'(data), 0);
        rst_n = 1'b1;
        model_valid = 1'b1;
        idle(BIT);

        // Single byte with latency window around 9.5 bit times (456 clk)
        fork
            send_byte(8'h55, 1'b1);
            begin
                @(negedge clk);
                lat = 0;
                while (empty && lat < 700) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("latency_window", int'(lat >= 450 && lat <= 462), 1);
        chk("single_no_ferr", ferr_cnt, 0);
        pop_expect(8'h55);
        @(negedge clk);
        chk("empty_after_pop", int'(empty), 1);

        // Back-to-back frames
        send_byte(8'hA3, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        pop_expect(8'hA3);
        pop_expect(8'h00);
        pop_expect(8'hFF);

        // Glitch shorter than half a bit
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (12) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_start", int'(busy), 1);
        repeat (24) @(negedge clk);
        chk("glitch_busy_end", int'(busy), 0);
        idle(BIT);
        chk("glitch_no_ferr", ferr_cnt, 0);

        // Framing error then a good byte
        send_byte(8'h3C, 1'b0);
        idle(2 * BIT);
        chk("ferr_one_pulse", ferr_cnt, 1);
        chk("ferr_empty", int'(empty), 1);
        send_byte(8'h81, 1'b1);
        pop_expect(8'h81);

        // Overflow: 17 bytes without popping
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        chk("full_after_16", int'(full), 1);
        chk("no_ovf_yet", ovf_cnt, 0);
        send_byte(8'h10, 1'b1);
        chk("ovf_one_pulse", ovf_cnt, 1);
        for (int i = 0; i < 16; i++) pop_expect(8'(i));

        // Pop on the 17th stop-decision clock: byte accepted, no overflow
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        fork
            send_byte(8'h10, 1'b1);
            begin
                @(negedge clk);
                repeat (455) @(negedge clk);
                chk("full_before_simul", int'(full), 1);
                get = 1'b1;
                if (mq.size() != 0) void'(mq.pop_front());
                @(negedge clk);
                get = 1'b0;
            end
        join
        chk("simul_no_ovf", ovf_cnt, 1);
        chk("simul_full", int'(full), 1);
        for (int i = 1; i <= 16; i++) pop_expect(8'(i));

        // Reset during bit 4 of 0x96 with one byte queued
        send_byte(8'h5A, 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i == 1 || i == 2) ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (24) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        model_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_full", int'(full), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        model_valid = 1'b1;
        idle(3 * BIT);
        chk("post_rst_no_push", int'(empty), 1);
        send_byte(8'h96, 1'b1);
        pop_expect(8'h96);

        idle(4);
        chk("total_ferr", ferr_cnt, 1);
        chk("total_ovf", ovf_cnt, 1);
        chk("model_ferr", ferr_cnt, exp_ferr);
        chk("model_ovf", ovf_cnt, exp_ovf);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
